// File: rtl/accumulator_sequencer.sv
// Accumulator/flag register stage around an 8-bit adder/subtractor.
// Handles LOAD/ADD/SUB in one cycle and an 8x8 shift-and-add multiply in eight.
module accumulator_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [0:2] op,
  input  logic [0:7] operand,
  output logic [0:7] acc,
  output logic [0:7] acc_hi,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

  localparam logic [2:0] OpLoad = 3'd1;
  localparam logic [2:0] OpAdd  = 3'd2;
  localparam logic [2:0] OpSub  = 3'd3;
  localparam logic [2:0] OpMul  = 3'd4;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] acc_hi_q, acc_hi_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [2:0] cnt_q, cnt_d;

  // Ports use [0:N-1] with index 0 as LSB; internal state is plain [N-1:0] numeric.
  logic [2:0] op_num;
  logic [7:0] operand_num;

  always_comb begin
    op_num      = '0;
    operand_num = '0;
    for (int i = 0; i < 3; i++) op_num[i] = op[i];
    for (int i = 0; i < 8; i++) operand_num[i] = operand[i];
  end

  always_comb begin
    acc    = '0;
    acc_hi = '0;
    for (int i = 0; i < 8; i++) begin
      acc[i]    = acc_q[i];
      acc_hi[i] = acc_hi_q[i];
    end
  end

  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign op_ready   = (state_q == StIdle);
  assign busy       = (state_q == StExec) || (state_q == StMul);
  assign done       = (state_q == StDone);

  // Shared adder/subtractor: A is acc in EXEC and acc_hi in MUL.
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_sub;
  logic [8:0]  add_res;
  logic [15:0] mul_next;

  always_comb begin
    add_a    = (state_q == StMul) ? acc_hi_q : acc_q;
    add_sub  = (state_q == StExec) && (op_q == OpSub);
    add_b    = add_sub ? ~b_q : b_q;
    add_res  = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_sub};
    mul_next = acc_q[0] ? {add_res[8], add_res[7:0], acc_q[7:1]}
                        : {1'b0, acc_hi_q, acc_q[7:1]};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    acc_hi_d = acc_hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          op_d = op_num;
          b_d  = operand_num;
          if (op_num == OpMul) begin
            state_d  = StMul;
            acc_hi_d = '0;
            cnt_d    = '0;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        state_d = StDone;
        case (op_q)
          OpLoad: begin
            acc_d   = b_q;
            carry_d = 1'b0;
            zero_d  = (b_q == 8'd0);
          end
          OpAdd, OpSub: begin
            acc_d   = add_res[7:0];
            carry_d = add_res[8];
            zero_d  = (add_res[7:0] == 8'd0);
          end
          default: ;
        endcase
      end
      StMul: begin
        {acc_hi_d, acc_d} = mul_next;
        cnt_d             = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          carry_d = (mul_next[15:8] != 8'd0);
          zero_d  = (mul_next == 16'd0);
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      acc_hi_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      acc_hi_q <= acc_hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer: arithmetic, multiply, timing, reset abort.
module tb_accumulator_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       op_valid;
  logic       op_ready;
  logic [0:2] op;
  logic [0:7] operand;
  logic [0:7] acc;
  logic [0:7] acc_hi;
  logic       carry_flag;
  logic       zero_flag;
  logic       busy;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;

  accumulator_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .operand    (operand),
    .acc        (acc),
    .acc_hi     (acc_hi),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Port vectors are [0:N-1] with index 0 the LSB.
  function automatic logic [0:7] p8(input logic [7:0] v);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [0:2] p3(input logic [2:0] v);
    logic [0:2] r;
    for (int i = 0; i < 3; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] num8(input logic [0:7] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one op and checks busy/done/op_ready timing; lat is edges from accept to done.
  task automatic run_op(input logic [2:0] o, input logic [7:0] v, input int lat);
    chk1("ready_before_accept", op_ready, 1'b1);
    op_valid = 1'b1;
    op       = p3(o);
    operand  = p8(v);
    step();
    op_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      chk1("busy_during_op", busy, 1'b1);
      chk1("done_early", done, 1'b0);
      step();
    end
    chk1("done_pulse", done, 1'b1);
    chk1("busy_in_done", busy, 1'b0);
    chk1("ready_in_done", op_ready, 1'b0);
    step();
    chk1("done_one_cycle", done, 1'b0);
    chk1("ready_after_done", op_ready, 1'b1);
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_acc, input logic [7:0] e_hi,
                           input logic e_c, input logic e_z);
    chk8({tag, "_acc"}, num8(acc), e_acc);
    chk8({tag, "_acc_hi"}, num8(acc_hi), e_hi);
    chk1({tag, "_carry"}, carry_flag, e_c);
    chk1({tag, "_zero"}, zero_flag, e_z);
  endtask

  initial begin
    reset_n  = 1'b0;
    op_valid = 1'b0;
    op       = p3(3'd0);
    operand  = p8(8'h00);
    step();
    step();
    chk_state("reset", 8'h00, 8'h00, 1'b0, 1'b1);
    chk1("reset_done", done, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_ready", op_ready, 1'b1);
    reset_n = 1'b1;

    run_op(3'd1, 8'h7F, 1);
    chk_state("load_7f", 8'h7F, 8'h00, 1'b0, 1'b0);
    run_op(3'd2, 8'h01, 1);
    chk_state("add_80", 8'h80, 8'h00, 1'b0, 1'b0);

    run_op(3'd1, 8'hFF, 1);
    run_op(3'd2, 8'h01, 1);
    chk_state("add_wrap", 8'h00, 8'h00, 1'b1, 1'b1);

    run_op(3'd1, 8'h05, 1);
    run_op(3'd3, 8'h07, 1);
    chk_state("sub_borrow", 8'hFE, 8'h00, 1'b0, 1'b0);
    run_op(3'd1, 8'h07, 1);
    run_op(3'd3, 8'h07, 1);
    chk_state("sub_zero", 8'h00, 8'h00, 1'b1, 1'b1);

    run_op(3'd1, 8'hFF, 1);
    run_op(3'd4, 8'hFF, 8);
    chk_state("mul_ff_ff", 8'h01, 8'hFE, 1'b1, 1'b0);
    run_op(3'd1, 8'h0F, 1);
    run_op(3'd4, 8'h11, 8);
    chk_state("mul_0f_11", 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op(3'd1, 8'h00, 1);
    run_op(3'd4, 8'h37, 8);
    chk_state("mul_zero", 8'h00, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a multiply with an ADD held on the request port.
    run_op(3'd1, 8'h5A, 1);
    op_valid = 1'b1;
    op       = p3(3'd4);
    operand  = p8(8'h03);
    step();
    op      = p3(3'd2);
    operand = p8(8'h23);
    for (int i = 1; i <= 3; i++) begin
      chk1("abort_busy", busy, 1'b1);
      chk1("abort_ready", op_ready, 1'b0);
      step();
    end
    reset_n = 1'b0;
    step();
    chk_state("abort", 8'h00, 8'h00, 1'b0, 1'b1);
    chk1("abort_no_done", done, 1'b0);
    chk1("abort_ready_after", op_ready, 1'b1);
    step();
    chk1("reset_beats_accept", busy, 1'b0);
    chk1("reset_hold_done", done, 1'b0);
    reset_n = 1'b1;
    step();
    chk1("held_add_accepted", busy, 1'b1);
    op_valid = 1'b0;
    step();
    chk1("held_add_done", done, 1'b1);
    chk_state("held_add", 8'h23, 8'h00, 1'b0, 1'b0);
    step();
    chk1("held_add_ready", op_ready, 1'b1);

    run_op(3'd6, 8'hAA, 1);
    chk_state("op6_nop", 8'h23, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
# accumulator_sequencer

Control and register stage wrapped around the team's 8-bit adder/subtractor. It holds the accumulator and flag registers, latches operands through a valid/ready handshake, and drives the shared adder with its registered operands. It writes the adder's sum and carry back into the accumulator and flags. A shift-and-add sequence reuses the same adder for an 8x8 multiply.

## Interface
- No parameters. Data width is fixed at 8 bits.
- All vectors are declared [0:N-1], with bit 0 the LSB, matching the adder/subtractor.
- `clock`  in  1  — sole clock; all state changes on its rising edge.
- `reset_n`  in  1  — synchronous, active-low reset, sampled on the rising edge of `clock`.
- `op_valid`  in  1  — requester presents `op` and `operand`.
- `op_ready`  out  1  — block can accept an op this cycle.
- `op`  in  3  — opcode, numeric value with bit 0 the LSB:
  - 0 = NOP, 1 = LOAD, 2 = ADD, 3 = SUB, 4 = MUL.
  - 5-7 execute as NOP.
- `operand`  in  8  — B operand, or the load value.
- `acc`  out  8  — accumulator; low byte of the product after MUL.
- `acc_hi`  out  8  — high byte of the product; written only by MUL.
- `carry_flag`  out  1  — carry / no-borrow flag.
- `zero_flag`  out  1  — result-is-zero flag.
- `busy`  out  1  — high in EXEC and MUL.
- `done`  out  1  — one-cycle completion pulse.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - `op_ready`=1.
  - On an edge with `op_valid` && `op_ready`, latch `op` and `operand` into `op_q` and `b_q`.
  - MUL goes to MUL; every other opcode goes to EXEC.
  - `op_valid` outside IDLE is ignored; nothing is queued.
- EXEC lasts one cycle. The adder is fed A=`acc`, B=`b_q`, subtract=(op_q==SUB). On the exit edge:
  - LOAD: `acc`=`b_q`; `carry_flag`=0; `zero_flag`=(`b_q`==0).
  - ADD: `acc`=`acc`+`b_q` mod 256; `carry_flag`=carry out of bit 7; `zero_flag`=(result==0).
  - SUB: `acc`=`acc`+~`b_q`+1 mod 256; `carry_flag`=adder carry, so 1 = no borrow and 0 = borrow; `zero_flag`=(result==0).
  - NOP: no register changes.
  - Then go to DONE.
- MUL: the multiplier is `acc`, the multiplicand is `b_q`. Lasts exactly 8 cycles, with a 3-bit count 0..7.
  - On entry: `acc_hi`=0, count=0.
  - Each cycle the adder computes `acc_hi`+`b_q` (subtract=0), giving carry c and sum s.
  - If `acc`[0]=1: {`acc_hi`,`acc`} = {c, s, `acc`[7:1]}, i.e. a 17-bit right shift.
  - Else: {`acc_hi`,`acc`} = {0, `acc_hi`, `acc`[7:1]}.
  - On the edge where count==7: `carry_flag`=(final `acc_hi`!=0); `zero_flag`=(16-bit product==0); go to DONE.
  - Count wrap from 7 to 0 is never observed outside MUL.
- DONE: `done`=1, `op_ready`=0, `busy`=0; go to IDLE on the next edge.
- While in IDLE, the adder's inputs are don't-care; outputs hold.
- Reset (`reset_n`=0 at an edge), from any state including mid-MUL:
  - state=IDLE; `acc`=0x00, `acc_hi`=0x00.
  - `carry_flag`=0, `zero_flag`=1.
  - `done`=0, `busy`=0.
  - The in-flight op is discarded with no `done` pulse.
  - `op_ready` is 1 in the first cycle after reset.
  - Reset has priority over an accept on the same edge.

## Timing
- Define edge 0 as the accept edge.
- LOAD/ADD/SUB/NOP:
  - `busy` high for the cycle after edge 0.
  - Result and flags are visible after edge 1.
  - `done` high between edge 1 and edge 2.
  - `op_ready` returns after edge 2, giving 3-cycle throughput.
- MUL:
  - `busy` high for 8 cycles (edges 1-8).
  - Product visible after edge 8.
  - `done` high between edge 8 and edge 9.
  - `op_ready` after edge 9.
- Intermediate `acc`/`acc_hi` values are visible during MUL and are not architecturally valid until `done`.
- All outputs are registered, or decoded directly from state (`op_ready`, `busy`, `done`). There are no combinational input-to-output paths.

## Test plan
- Reset, then LOAD 0x7F, ADD 0x01 -> after ADD `done`: `acc`=0x80, `carry_flag`=0, `zero_flag`=0. Also checks that `done` is exactly one cycle wide.
- LOAD 0xFF, ADD 0x01 -> `acc`=0x00, `carry_flag`=1, `zero_flag`=1.
- LOAD 0x05, SUB 0x07 -> `acc`=0xFE, `carry_flag`=0. Then LOAD 0x07, SUB 0x07 -> `acc`=0x00, `carry_flag`=1, `zero_flag`=1.
- LOAD 0xFF, MUL 0xFF -> `done` between edges 8 and 9 after the accept edge; `acc_hi`=0xFE, `acc`=0x01, `carry_flag`=1. Then LOAD 0x0F, MUL 0x11 -> `acc_hi`=0x00, `acc`=0xFF, `carry_flag`=0. Then LOAD 0x00, MUL 0x37 -> `zero_flag`=1.
- Accept MUL, hold `op_valid`=1 with ADD throughout, assert `reset_n`=0 at MUL edge 4 -> no `done`; `acc`=0x00, `acc_hi`=0x00, `zero_flag`=1; `op_ready`=1 the following cycle. The held ADD is then accepted only once `reset_n`=1 and the block is in IDLE.
- Opcode 6 with `operand`=0xAA -> behaves as NOP: `done` pulses after edge 1 and `acc`/flags are unchanged.
